// File: rtl/turn_sig_pkg.sv
// Shared definitions for the left and right turn-signal sequencers:
// state encoding, LED patterns for both clusters and the default step rate.
package turn_sig_pkg;

  localparam int TICK_DIV_DEFAULT = 50;
  localparam int NLED             = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    L1     = 3'd1,
    L2     = 3'd2,
    L3     = 3'd3,
    OFF    = 3'd4,
    HZ_ON  = 3'd5,
    HZ_OFF = 3'd6
  } state_t;

  // leds[2] is the innermost lamp on the left cluster, leds[0] on the right
  localparam logic [NLED-1:0] LEFT_L1  = 3'b100;
  localparam logic [NLED-1:0] LEFT_L2  = 3'b110;
  localparam logic [NLED-1:0] LEFT_L3  = 3'b111;
  localparam logic [NLED-1:0] RIGHT_L1 = 3'b001;
  localparam logic [NLED-1:0] RIGHT_L2 = 3'b011;
  localparam logic [NLED-1:0] RIGHT_L3 = 3'b111;
  localparam logic [NLED-1:0] LED_OFF  = 3'b000;
  localparam logic [NLED-1:0] LED_ALL  = 3'b111;

  function automatic logic [NLED-1:0] left_pattern(input state_t s);
    logic [NLED-1:0] p;
    case (s)
      L1:      p = LEFT_L1;
      L2:      p = LEFT_L2;
      L3:      p = LEFT_L3;
      HZ_ON:   p = LED_ALL;
      default: p = LED_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/turn_tick_prescaler.sv
// Step-rate prescaler shared by the turn-signal sequencers: pulses tick on
// the last count of each TICK_DIV-cycle step while run is high.
module turn_tick_prescaler #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // clr wins over run so a restart always begins a full step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/left_turn_fsm.sv
// Left tail-light sequencer: L1 -> L2 -> L3 -> OFF while enabled, wrap on L3->OFF.
// Optional hazard flasher (haz input, HZ_ON/HZ_OFF) under LEFT_TURN_FSM_HAZARD_EN.
import turn_sig_pkg::*;

module left_turn_fsm #(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
`ifdef LEFT_TURN_FSM_HAZARD_EN
  input  logic            haz,
`endif
  output logic [NLED-1:0] leds,
  output logic            wrap
);

  state_t          r_state;
  state_t          w_next;
  logic [NLED-1:0] r_leds;
  logic [NLED-1:0] w_leds_next;
  logic            r_wrap;
  logic            w_wrap_next;
  logic            w_tick;
  logic            w_run;
  logic            w_clr;

`ifdef LEFT_TURN_FSM_HAZARD_EN
  logic w_in_hz;
  assign w_in_hz = (r_state == HZ_ON) || (r_state == HZ_OFF);
  assign w_run   = (r_state != IDLE) && (ena || haz);
  assign w_clr   = (w_next == IDLE) || (r_state == IDLE) ||
                   ((w_next == HZ_ON) && !w_in_hz);
`else
  assign w_run   = (r_state != IDLE) && ena;
  assign w_clr   = (w_next == IDLE) || (r_state == IDLE);
`endif

  turn_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (w_run),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // State and outputs are registered together so no input reaches a pin combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_leds  <= LED_OFF;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_leds  <= w_leds_next;
      r_wrap  <= w_wrap_next;
    end
  end

  // Next-state selection; hazard beats ena, and ena=0 beats tick
  always_comb begin
    w_next = r_state;
`ifdef LEFT_TURN_FSM_HAZARD_EN
    if (haz) begin
      if (r_state == HZ_ON) begin
        w_next = w_tick ? HZ_OFF : HZ_ON;
      end else if (r_state == HZ_OFF) begin
        w_next = w_tick ? HZ_ON : HZ_OFF;
      end else begin
        w_next = HZ_ON;
      end
    end else if (w_in_hz || !ena) begin
      w_next = IDLE;
    end else begin
`else
    if (!ena) begin
      w_next = IDLE;
    end else begin
`endif
      case (r_state)
        IDLE:    w_next = L1;
        L1:      w_next = w_tick ? L2  : L1;
        L2:      w_next = w_tick ? L3  : L2;
        L3:      w_next = w_tick ? OFF : L3;
        OFF:     w_next = w_tick ? L1  : OFF;
        default: w_next = IDLE;
      endcase
    end
  end

  // Output values for the state being entered
  always_comb begin
    w_leds_next = left_pattern(w_next);
    w_wrap_next = 1'b0;
    if ((r_state == L3) && (w_next == OFF)) begin
      w_wrap_next = 1'b1;
    end else begin
      w_wrap_next = 1'b0;
    end
  end

  assign leds = r_leds;
  assign wrap = r_wrap;

endmodule
